multi_pulse_timer: RTL

- Multi-channel programmable pulse generator; successor to the single-channel fixed toggle timer.
- Each channel has its own period, high time and mode (continuous or one-shot).
- Outputs a registered pulse waveform plus a period-start strobe per channel.
- Sits beside the controller FSMs as the shared timing source for motor/servo/LED pulse trains on the 50 MHz clk.

---
 rtl/multi_pulse_timer.sv | 223 ++++++++++++++++++++++
 1 files changed

// File: rtl/multi_pulse_timer.sv
// -----------------------------------------------------------------------------
// multi_pulse_timer
//
// Multi-channel programmable pulse generator. Every channel runs its own
// period / high-time counter in continuous or one-shot mode and drives a
// registered pulse waveform, a period-start strobe and a busy flag.
//
// Parameters
//   NUM_CH  number of independent channels (1..16)
//   CNT_W   counter / period / high-time width
//   CH_W    width of cfg_ch, 2**CH_W >= NUM_CH
//
// Ports
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   cfg_we       one-cycle configuration write strobe
//   cfg_ch       channel addressed by the write (values >= NUM_CH ignored)
//   cfg_period   period value P, channel period is P+1 cycles
//   cfg_high     high time H in cycles
//   cfg_oneshot  1 = one-shot, 0 = continuous
//   ch_en        per-channel enable level
//   start        per-channel one-shot trigger pulse
//   pulse_out    registered pulse waveform
//   tick         one-cycle strobe on the first cycle of each period
//   busy         channel is in RUN
//
// Optional build macro MULTI_PULSE_TIMER_IRQ_EN adds:
//   irq_clr      per-channel sticky status clear (in)
//   irq          OR of irq_status (out)
//   irq_status   sticky per-channel period-complete flags (out)
//
// Per-channel FSM
//   state  | meaning
//   IDLE   | counter held at 0, outputs low, config writes go straight to active
//   RUN    | counter advancing, config writes land in shadow until next wrap
// -----------------------------------------------------------------------------
module multi_pulse_timer #(
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 32,
   parameter int CH_W   = 2
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              cfg_we,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_period,
   input  logic [CNT_W-1:0]  cfg_high,
   input  logic              cfg_oneshot,
   input  logic [NUM_CH-1:0] ch_en,
   input  logic [NUM_CH-1:0] start,
`ifdef MULTI_PULSE_TIMER_IRQ_EN
   input  logic [NUM_CH-1:0] irq_clr,
   output logic              irq,
   output logic [NUM_CH-1:0] irq_status,
`endif
   output logic [NUM_CH-1:0] pulse_out,
   output logic [NUM_CH-1:0] tick,
   output logic [NUM_CH-1:0] busy
);

   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_RUN  = 1'b1;

   logic [0:0]       state_q   [NUM_CH];
   logic [0:0]       state_d   [NUM_CH];
   logic [CNT_W-1:0] cnt_q     [NUM_CH];
   logic [CNT_W-1:0] cnt_d     [NUM_CH];
   logic [CNT_W-1:0] per_q     [NUM_CH];
   logic [CNT_W-1:0] per_d     [NUM_CH];
   logic [CNT_W-1:0] high_q    [NUM_CH];
   logic [CNT_W-1:0] high_d    [NUM_CH];
   logic [CNT_W-1:0] sh_per_q  [NUM_CH];
   logic [CNT_W-1:0] sh_per_d  [NUM_CH];
   logic [CNT_W-1:0] sh_high_q [NUM_CH];
   logic [CNT_W-1:0] sh_high_d [NUM_CH];

   logic [NUM_CH-1:0] os_q, os_d;
   logic [NUM_CH-1:0] sh_os_q, sh_os_d;
   logic [NUM_CH-1:0] pulse_q, pulse_d;
   logic [NUM_CH-1:0] tick_q, tick_d;
   logic [NUM_CH-1:0] busy_q, busy_d;
`ifdef MULTI_PULSE_TIMER_IRQ_EN
   logic [NUM_CH-1:0] set_irq;
   logic [NUM_CH-1:0] irq_q, irq_d;
`endif

   always_comb begin
      logic wr_hit;
      logic at_end;
      logic enter_run;
      for (int i = 0; i < NUM_CH; i++) begin
         state_d[i]   = state_q[i];
         cnt_d[i]     = cnt_q[i];
         per_d[i]     = per_q[i];
         high_d[i]    = high_q[i];
         os_d[i]      = os_q[i];
         sh_per_d[i]  = sh_per_q[i];
         sh_high_d[i] = sh_high_q[i];
         sh_os_d[i]   = sh_os_q[i];
         tick_d[i]    = 1'b0;
`ifdef MULTI_PULSE_TIMER_IRQ_EN
         set_irq[i]   = 1'b0;
`endif
         // Out-of-range channel numbers never match any i, so they drop out here.
         wr_hit    = cfg_we && (int'(cfg_ch) == i);
         at_end    = (cnt_q[i] == per_q[i]);
         enter_run = ch_en[i] && (!os_q[i] || start[i]);

         // Shadow always tracks the latest write, so loading it at a wrap also
         // covers a write landing in the wrap cycle itself.
         if (wr_hit) begin
            sh_per_d[i]  = cfg_period;
            sh_high_d[i] = cfg_high;
            sh_os_d[i]   = cfg_oneshot;
         end

         case (state_q[i])
            S_IDLE: begin
               if (wr_hit) begin
                  per_d[i]  = cfg_period;
                  high_d[i] = cfg_high;
                  os_d[i]   = cfg_oneshot;
               end
               if (enter_run) begin
                  state_d[i] = S_RUN;
                  cnt_d[i]   = '0;
                  tick_d[i]  = 1'b1;
               end
            end
            S_RUN: begin
               if (!ch_en[i]) begin
                  // A write pending in shadow becomes active once the channel
                  // is idle, matching what a write in IDLE would have done.
                  state_d[i] = S_IDLE;
                  cnt_d[i]   = '0;
                  per_d[i]   = sh_per_d[i];
                  high_d[i]  = sh_high_d[i];
                  os_d[i]    = sh_os_d[i];
               end else if (at_end) begin
                  per_d[i]   = sh_per_d[i];
                  high_d[i]  = sh_high_d[i];
                  os_d[i]    = sh_os_d[i];
                  cnt_d[i]   = '0;
`ifdef MULTI_PULSE_TIMER_IRQ_EN
                  set_irq[i] = 1'b1;
`endif
                  if (os_q[i]) begin
                     state_d[i] = S_IDLE;
                  end else begin
                     tick_d[i] = 1'b1;
                  end
               end else begin
                  cnt_d[i] = cnt_q[i] + CNT_W'(1);
               end
            end
            default: begin
               state_d[i] = S_IDLE;
               cnt_d[i]   = '0;
            end
         endcase

         // Outputs are registered from next-state values so they line up with
         // the counter value they describe.
         busy_d[i]  = (state_d[i] == S_RUN);
         pulse_d[i] = busy_d[i] && (cnt_d[i] < high_d[i]);
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]   <= S_IDLE;
            cnt_q[i]     <= '0;
            per_q[i]     <= '0;
            high_q[i]    <= '0;
            sh_per_q[i]  <= '0;
            sh_high_q[i] <= '0;
         end
         os_q    <= '0;
         sh_os_q <= '0;
         pulse_q <= '0;
         tick_q  <= '0;
         busy_q  <= '0;
      end else begin
         for (int i = 0; i < NUM_CH; i++) begin
            state_q[i]   <= state_d[i];
            cnt_q[i]     <= cnt_d[i];
            per_q[i]     <= per_d[i];
            high_q[i]    <= high_d[i];
            sh_per_q[i]  <= sh_per_d[i];
            sh_high_q[i] <= sh_high_d[i];
         end
         os_q    <= os_d;
         sh_os_q <= sh_os_d;
         pulse_q <= pulse_d;
         tick_q  <= tick_d;
         busy_q  <= busy_d;
      end
   end

   assign pulse_out = pulse_q;
   assign tick      = tick_q;
   assign busy      = busy_q;

`ifdef MULTI_PULSE_TIMER_IRQ_EN
   // Set wins over clear when both happen in the same cycle.
   always_comb begin
      irq_d = set_irq | (irq_q & ~irq_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         irq_q <= '0;
      end else begin
         irq_q <= irq_d;
      end
   end

   assign irq_status = irq_q;
   assign irq        = |irq_q;
`endif

endmodule
